// File: rtl/fpnew_lane_iter_div_if.sv
// fpnew_lane_iter_div_if: aux-FSM to lane handshake plus divider operands and results.
interface fpnew_lane_iter_div_if #(parameter int Width = 24);
  logic             fsm_start_i;
  logic             lane_active_i;
  logic [Width-1:0] dividend_i;
  logic [Width-1:0] divisor_i;
  logic             flush_i;
  logic             fsm_ready_o;
  logic [Width-1:0] quotient_o;
  logic [Width-1:0] remainder_o;
  logic             div_by_zero_o;
  logic             busy_o;
  modport master (
    output fsm_start_i, lane_active_i, dividend_i, divisor_i, flush_i,
    input  fsm_ready_o, quotient_o, remainder_o, div_by_zero_o, busy_o
  );
  modport slave (
    input  fsm_start_i, lane_active_i, dividend_i, divisor_i, flush_i,
    output fsm_ready_o, quotient_o, remainder_o, div_by_zero_o, busy_o
  );
endinterface

// File: rtl/fpnew_lane_iter_div.sv
// fpnew_lane_iter_div: lane responder doing unsigned radix-2 restoring division, one quotient bit per cycle.
module fpnew_lane_iter_div #(
  parameter int Width = 24
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  fpnew_lane_iter_div_if.slave   bus
);
  localparam int CW = $clog2(Width);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [Width-1:0] q_q, q_d, r_q, r_d, d_q, d_d, diff;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d, ge;
  logic [Width:0]   t;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end
  // t - D fits in Width bits whenever t >= D, so the low bits suffice
  always_comb begin
    t       = {r_q, q_q[Width-1]};
    ge      = t >= {1'b0, d_q};
    diff    = t[Width-1:0] - d_q;
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      q_d     = '0;
      r_d     = '0;
      cnt_d   = '0;
      dbz_d   = 1'b0;
    end else if (bus.fsm_start_i) begin
      if (!bus.lane_active_i) begin
        state_d = DONE;
        q_d     = '0;
        r_d     = '0;
        dbz_d   = 1'b0;
      end else if (bus.divisor_i == '0) begin
        state_d = DONE;
        q_d     = '1;
        r_d     = bus.dividend_i;
        dbz_d   = 1'b1;
      end else begin
        state_d = RUN;
        q_d     = bus.dividend_i;
        r_d     = '0;
        d_d     = bus.divisor_i;
        cnt_d   = CW'(Width - 1);
        dbz_d   = 1'b0;
      end
    end else if (state_q == RUN) begin
      q_d     = {q_q[Width-2:0], ge};
      r_d     = ge ? diff : t[Width-1:0];
      state_d = (cnt_q == '0) ? DONE : RUN;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end else if (state_q != IDLE && state_q != DONE) begin
      state_d = IDLE;
    end
  end
  assign bus.fsm_ready_o   = (state_q != RUN);
  assign bus.busy_o        = (state_q == RUN);
  assign bus.quotient_o    = q_q;
  assign bus.remainder_o   = r_q;
  assign bus.div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_fpnew_lane_iter_div.sv
// tb_fpnew_lane_iter_div: directed vectors on an 8-bit and a 24-bit lane with hand-computed results.
module tb_fpnew_lane_iter_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  fpnew_lane_iter_div_if #(.Width(8))  b8 ();
  fpnew_lane_iter_div_if #(.Width(24)) b24 ();
  fpnew_lane_iter_div #(.Width(8))  dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(b8.slave));
  fpnew_lane_iter_div #(.Width(24)) dut24 (.clk_i(clk), .rst_ni(rst_n), .bus(b24.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go8(input logic act, input logic [7:0] a, input logic [7:0] b);
    b8.fsm_start_i = 1'b1;
    b8.lane_active_i = act;
    b8.dividend_i = a;
    b8.divisor_i = b;
    step();
    b8.fsm_start_i = 1'b0;
  endtask
  task automatic run8(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_ready_low"}, 32'(b8.fsm_ready_o), 32'd0);
      check({tag, "_busy"}, 32'(b8.busy_o), 32'd1);
      step();
    end
  endtask
  task automatic res8(input string tag, input logic [7:0] q, input logic [7:0] r, input logic z);
    check({tag, "_ready"}, 32'(b8.fsm_ready_o), 32'd1);
    check({tag, "_quot"}, 32'(b8.quotient_o), 32'(q));
    check({tag, "_rem"}, 32'(b8.remainder_o), 32'(r));
    check({tag, "_dbz"}, 32'(b8.div_by_zero_o), 32'(z));
  endtask
  initial begin
    b8.fsm_start_i = 1'b0; b8.lane_active_i = 1'b1; b8.dividend_i = '0; b8.divisor_i = '0; b8.flush_i = 1'b0;
    b24.fsm_start_i = 1'b0; b24.lane_active_i = 1'b1; b24.dividend_i = '0; b24.divisor_i = '0; b24.flush_i = 1'b0;
    #2;
    res8("reset", 8'd0, 8'd0, 1'b0);
    check("reset_busy", 32'(b8.busy_o), 32'd0);
    #10 rst_n = 1'b1;
    step();
    go8(1'b1, 8'd200, 8'd7);
    run8("d200_7", 8);
    res8("d200_7", 8'd28, 8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      res8("d200_7_hold", 8'd28, 8'd4, 1'b0);
    end
    go8(1'b1, 8'd13, 8'd0);
    res8("dbz", 8'hFF, 8'd13, 1'b1);
    check("dbz_busy0", 32'(b8.busy_o), 32'd0);
    step();
    check("dbz_busy1", 32'(b8.busy_o), 32'd0);
    go8(1'b0, 8'd50, 8'd3);
    res8("inactive", 8'd0, 8'd0, 1'b0);
    go8(1'b1, 8'd255, 8'd1);
    run8("d255_1", 8);
    res8("d255_1", 8'd255, 8'd0, 1'b0);
    step();
    res8("d255_1_hold", 8'd255, 8'd0, 1'b0);
    go8(1'b1, 8'd100, 8'd10);
    run8("b2b", 8);
    res8("b2b", 8'd10, 8'd0, 1'b0);
    go8(1'b1, 8'd200, 8'd7);
    step(); step(); step();
    b8.flush_i = 1'b1;
    go8(1'b1, 8'd9, 8'd2);
    b8.flush_i = 1'b0;
    res8("flush", 8'd0, 8'd0, 1'b0);
    check("flush_busy", 32'(b8.busy_o), 32'd0);
    go8(1'b1, 8'd9, 8'd2);
    run8("d9_2", 8);
    res8("d9_2", 8'd4, 8'd1, 1'b0);
    b24.fsm_start_i = 1'b1; b24.dividend_i = 24'hFFFFFF; b24.divisor_i = 24'h000003;
    step();
    b24.fsm_start_i = 1'b0;
    step(); step();
    check("w24_busy_pre", 32'(b24.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("w24_rst_ready", 32'(b24.fsm_ready_o), 32'd1);
    check("w24_rst_busy", 32'(b24.busy_o), 32'd0);
    check("w24_rst_quot", 32'(b24.quotient_o), 32'd0);
    check("w24_rst_rem", 32'(b24.remainder_o), 32'd0);
    check("w24_rst_dbz", 32'(b24.div_by_zero_o), 32'd0);
    #4 rst_n = 1'b1;
    step();
    b24.fsm_start_i = 1'b1;
    step();
    b24.fsm_start_i = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      check("w24_ready_low", 32'(b24.fsm_ready_o), 32'd0);
      step();
    end
    check("w24_ready", 32'(b24.fsm_ready_o), 32'd1);
    check("w24_quot", 32'(b24.quotient_o), 32'h555555);
    check("w24_rem", 32'(b24.remainder_o), 32'd0);
    check("w24_dbz", 32'(b24.div_by_zero_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/fpnew_lane_iter_div.md
Name: fpnew_lane_iter_div

Overview:
- Lane-side responder of the shared-handshake FSM protocol: one instance per lane of an iterative (multi-cycle) FPNew operation group.
- The aux chain pulses `fsm_start_i` once per operation and waits until every lane reports `fsm_ready_o`.
- This block is an unsigned radix-2 restoring mantissa divider. It latches operands on start, iterates one quotient bit per cycle, then holds its result stable until the next start.

Parameters:
- Width, 24, operand/quotient/remainder width in bits (≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- fsm_start_i  in  1  start pulse from the aux FSM; operands are sampled in this cycle.
- lane_active_i  in  1  lane participates in the operation; sampled with start.
- dividend_i  in  Width  dividend.
- divisor_i  in  Width  divisor.
- flush_i  in  1  synchronous abort.
- fsm_ready_o  out  1  lane done, or idle; results valid.
- quotient_o  out  Width  quotient.
- remainder_o  out  Width  remainder.
- div_by_zero_o  out  1  last operation had divisor == 0 (active lane only).
- busy_o  out  1  iteration in progress.

Behaviour:
- States: IDLE, RUN, DONE. Encode in 2 bits; an illegal encoding goes to IDLE.
- Reset values: state = IDLE, fsm_ready_o = 1, busy_o = 0, quotient_o = 0, remainder_o = 0, div_by_zero_o = 0, internal counter = 0.
- `fsm_ready_o` = 1 in IDLE and DONE, 0 in RUN. It is a registered-state decode only; there is no combinational path from `fsm_start_i`.
- `busy_o` = (state == RUN).
- `fsm_start_i` is accepted in any state, with this priority: flush > start > iterate.
- Inactive lane (`lane_active_i` = 0 at start):
  - next state DONE;
  - quotient = 0, remainder = 0, div_by_zero = 0.
- Active lane, `divisor_i` == 0:
  - next state DONE;
  - quotient = all-ones, remainder = `dividend_i`, div_by_zero = 1.
- Active lane, nonzero divisor:
  - load Q = `dividend_i`, R = 0, D = `divisor_i`, counter = Width-1, div_by_zero = 0;
  - next state RUN.
- RUN iteration, each cycle:
  - T = {R, Q[Width-1]} (Width+1 bits); Q <= Q << 1.
  - If T ≥ {1'b0, D}: R <= T − D and Q[0] <= 1. Otherwise R <= T[Width-1:0] and Q[0] <= 0.
  - When counter == 0, the next state is DONE; otherwise the counter decrements.
- Latency: start in cycle 0 → RUN in cycles 1..Width → `fsm_ready_o` = 1 with final results from cycle Width+1. The zero-divisor and inactive-lane cases are ready in cycle 1.
- `quotient_o` and `remainder_o` are driven directly from Q and R. They are held unchanged in DONE and IDLE until the next accepted start. Intermediate values are visible during RUN and are don't-care while `fsm_ready_o` = 0.
- Start while in DONE (back-to-back operation from the aux chain): reload the operands and go to RUN in the same edge. `fsm_ready_o` drops in the next cycle.
- Start while in RUN (protocol violation): restart the operation with the new operands. No error flag.
- `flush_i` in any state:
  - next state IDLE;
  - Q, R, and div_by_zero cleared to 0, counter = 0;
  - a coincident start is ignored.
- Reset asserted mid-RUN: immediately (asynchronously) return to the reset values.

Test Plan:
- Width=8; start with active lane, 200/7 → `fsm_ready_o` low in cycles 1–8, high in cycle 9; quotient_o = 28, remainder_o = 4, div_by_zero_o = 0. Outputs hold for 5 further idle cycles.
- Width=8; 13/0 → cycle 1: ready = 1, quotient_o = 0xFF, remainder_o = 13, div_by_zero_o = 1, busy_o never asserted.
- Width=8; lane_active_i = 0 with 50/3 → cycle 1: ready = 1, quotient_o = 0, remainder_o = 0.
- Width=8; 255/1 completes, then immediate start in DONE with 100/10 → ready low in the next 8 cycles, then quotient_o = 10, remainder_o = 0. The first result (255, 0) is visible until the second start.
- Width=8; 200/7 started, `flush_i` in cycle 4 together with a new start → IDLE next cycle, ready = 1, quotient_o = 0, remainder_o = 0, busy_o = 0. A fresh 9/2 then yields 4 r 1 after 9 cycles.
- Width=24; rst_ni pulsed low mid-RUN of 0xFFFFFF/0x000003 → outputs return to reset values asynchronously. After release, the same operation yields quotient 0x555555, remainder 0 in cycle 25.
